// File: rtl/mem_lsu_pkg.sv
// mem_lsu_pkg: MIPS memory opcodes, LSU FSM states and opcode class helpers.
package mem_lsu_pkg;
  localparam logic [5:0] EXE_LB  = 6'h20;
  localparam logic [5:0] EXE_LH  = 6'h21;
  localparam logic [5:0] EXE_LW  = 6'h23;
  localparam logic [5:0] EXE_LBU = 6'h24;
  localparam logic [5:0] EXE_LHU = 6'h25;
  localparam logic [5:0] EXE_SB  = 6'h28;
  localparam logic [5:0] EXE_SH  = 6'h29;
  localparam logic [5:0] EXE_SW  = 6'h2b;
  typedef enum logic [1:0] {LSU_IDLE, LSU_BUSY, LSU_DONE} lsu_state_e;
  function automatic logic is_load(input logic [5:0] op);
    return op == EXE_LB || op == EXE_LH || op == EXE_LW || op == EXE_LBU || op == EXE_LHU;
  endfunction
  function automatic logic is_store(input logic [5:0] op);
    return op == EXE_SB || op == EXE_SH || op == EXE_SW;
  endfunction
  function automatic logic is_half(input logic [5:0] op);
    return op == EXE_LH || op == EXE_LHU || op == EXE_SH;
  endfunction
  function automatic logic is_word(input logic [5:0] op);
    return op == EXE_LW || op == EXE_SW;
  endfunction
endpackage

// File: rtl/mem_lsu_load_ext.sv
// lsu_load_ext: selects the addressed byte/halfword of a load word and sign/zero-extends it.
module lsu_load_ext
  import mem_lsu_pkg::*;
(
  input  logic [5:0]  op,
  input  logic [1:0]  addr,
  input  logic [31:0] word,
  output logic [31:0] result
);
  logic [7:0]  byt;
  logic [15:0] half;
  assign byt  = word[{addr, 3'b000} +: 8];
  assign half = addr[1] ? word[31:16] : word[15:0];
  assign result = op == EXE_LB  ? {{24{byt[7]}}, byt} :
                  op == EXE_LBU ? {24'b0, byt} :
                  op == EXE_LH  ? {{16{half[15]}}, half} :
                  op == EXE_LHU ? {16'b0, half} :
                  op == EXE_LW  ? word : 32'b0;
endmodule

// File: rtl/mem_lsu.sv
// mem_lsu: MEM-stage load/store unit with byte-enable memory port and ready timeout; LSU_ALIGN_CHECK_EN enables misalignment errors.
module mem_lsu
  import mem_lsu_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [5:0]  req_op,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        mem_en,
  output logic [3:0]  mem_wen,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready
);
  localparam int CW = $clog2(TIMEOUT + 1);
  lsu_state_e state, state_nx;
  logic [5:0]    op_q;
  logic [31:0]   addr_q, wdata_q, rdata_q, ext;
  logic          err_q, mis, legal, busy, done, timeout;
  logic [CW-1:0] cnt;
  logic [3:0]    wen_c;
  logic [31:0]   wdata_c;
`ifdef LSU_ALIGN_CHECK_EN
  assign mis = (is_half(req_op) && req_addr[0]) || (is_word(req_op) && req_addr[1:0] != 2'b00);
`else
  assign mis = 1'b0;
`endif
  assign legal   = (is_load(req_op) || is_store(req_op)) && !mis;
  assign busy    = state == LSU_BUSY;
  assign done    = state == LSU_DONE;
  assign timeout = cnt == CW'(TIMEOUT);
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) state <= LSU_IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    state_nx = state == LSU_IDLE ? (req_valid ? (legal ? LSU_BUSY : LSU_DONE) : LSU_IDLE) :
               busy ? ((mem_ready || timeout) ? LSU_DONE : LSU_BUSY) : LSU_IDLE;
  end
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      op_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      cnt     <= '0;
    end else begin
      if (state == LSU_IDLE && req_valid) begin
        op_q    <= req_op;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        rdata_q <= '0;
        err_q   <= mis;
      end
      if (busy) begin
        cnt <= timeout ? cnt : cnt + 1'b1;
        if (mem_ready) rdata_q <= ext;
        else if (timeout) err_q <= 1'b1;
      end else cnt <= '0;
    end
  lsu_load_ext u_ext (
    .op     (op_q),
    .addr   (addr_q[1:0]),
    .word   (mem_rdata),
    .result (ext)
  );
  // Lane replication lets the memory pick the bytes it needs purely from mem_wen.
  assign wen_c   = op_q == EXE_SB ? 4'b0001 << addr_q[1:0] :
                   op_q == EXE_SH ? 4'b0011 << {addr_q[1], 1'b0} :
                   op_q == EXE_SW ? 4'b1111 : 4'b0000;
  assign wdata_c = op_q == EXE_SB ? {4{wdata_q[7:0]}} :
                   op_q == EXE_SH ? {2{wdata_q[15:0]}} :
                   op_q == EXE_SW ? wdata_q : 32'b0;
  assign req_ready  = state == LSU_IDLE;
  assign mem_en     = busy;
  assign mem_wen    = busy ? wen_c : 4'b0000;
  assign mem_addr   = busy ? {addr_q[31:2], 2'b00} : 32'b0;
  assign mem_wdata  = busy ? wdata_c : 32'b0;
  assign resp_valid = done;
  assign resp_rdata = done ? rdata_q : 32'b0;
  assign resp_err   = done && err_q;
endmodule

// File: tb/tb_mem_lsu.sv
// tb_mem_lsu: directed self-checking bench for mem_lsu (TIMEOUT=4), honouring LSU_ALIGN_CHECK_EN.
module tb_mem_lsu;
  import mem_lsu_pkg::*;
  logic        clk = 0, resetn = 0;
  logic        req_valid = 0, req_ready;
  logic [5:0]  req_op = '0;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic        resp_valid, resp_err, mem_en;
  logic [31:0] resp_rdata, mem_addr, mem_wdata;
  logic [3:0]  mem_wen;
  logic [31:0] mem_rdata = '0;
  logic        mem_ready = 0;
  int n_tests = 0, n_fail = 0;
  int lat, en_n;
  logic [3:0]  wen;
  logic [31:0] maddr, mwdata, rdata;
  logic        rerr, seen;
  mem_lsu #(.TIMEOUT(4)) dut (
    .clk(clk), .resetn(resetn), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_en(mem_en), .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  // d = BUSY cycles without mem_ready before it is raised; a large d never raises it.
  task automatic do_req(input logic [5:0] op, input logic [31:0] addr, input logic [31:0] wd,
                        input logic [31:0] rd, input int d);
    @(negedge clk);
    check("req_ready_idle", {31'b0, req_ready}, 1);
    check("resp_one_pulse", {31'b0, resp_valid}, 0);
    req_valid = 1; req_op = op; req_addr = addr; req_wdata = wd;
    mem_rdata = rd; mem_ready = 0;
    en_n = 0; lat = -1; wen = '0; maddr = '0; mwdata = '0; rdata = '0; rerr = 0;
    @(posedge clk);
    #1 req_valid = 0; req_op = '0;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      if (mem_en) begin
        en_n++;
        wen = mem_wen; maddr = mem_addr; mwdata = mem_wdata;
        mem_ready = (en_n == d + 1);
      end else mem_ready = 0;
      if (resp_valid) begin
        lat = c; rdata = resp_rdata; rerr = resp_err;
        break;
      end
    end
    mem_ready = 0;
    check("resp_seen", {31'b0, lat >= 0}, 1);
  endtask
  initial begin
    #200000 $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    #12;
    check("rst_req_ready", {31'b0, req_ready}, 1);
    check("rst_mem_en", {31'b0, mem_en}, 0);
    check("rst_resp_valid", {31'b0, resp_valid}, 0);
    check("rst_mem_wen", {28'b0, mem_wen}, 0);
    check("rst_resp_rdata", resp_rdata, 0);
    resetn = 1;
    do_req(EXE_SW, 32'h100, 32'hDEADBEEF, 0, 0);
    check("sw_wen", {28'b0, wen}, 32'hF);
    check("sw_addr", maddr, 32'h100);
    check("sw_wdata", mwdata, 32'hDEADBEEF);
    check("sw_lat", lat, 2);
    check("sw_err", {31'b0, rerr}, 0);
    check("sw_rdata", rdata, 0);
    do_req(EXE_SB, 32'h103, 32'h000000A5, 0, 0);
    check("sb_wen", {28'b0, wen}, 32'h8);
    check("sb_wdata", mwdata, 32'hA5A5A5A5);
    check("sb_addr", maddr, 32'h100);
    do_req(EXE_SH, 32'h200, 32'h0000BEEF, 0, 0);
    check("sh_lo_wen", {28'b0, wen}, 32'h3);
    check("sh_lo_wdata", mwdata, 32'hBEEFBEEF);
    do_req(EXE_LB, 32'h102, 32'h12F03456, 32'h12F03456, 0);
    check("lb_rdata", rdata, 32'hFFFFFFF0);
    check("lb_wen", {28'b0, wen}, 0);
    check("lb_lat", lat, 2);
    do_req(EXE_LBU, 32'h102, 0, 32'h12F03456, 0);
    check("lbu_rdata", rdata, 32'h000000F0);
    do_req(EXE_LHU, 32'h102, 0, 32'h12F03456, 0);
    check("lhu_rdata", rdata, 32'h000012F0);
    do_req(EXE_LH, 32'h100, 0, 32'h12F08456, 0);
    check("lh_rdata", rdata, 32'hFFFF8456);
    do_req(EXE_LB, 32'h101, 0, 32'h12F03456, 0);
    check("lb1_rdata", rdata, 32'h00000034);
    do_req(EXE_LW, 32'h200, 0, 32'hCAFEF00D, 4);
    check("lw_wait_en", en_n, 5);
    check("lw_wait_lat", lat, 6);
    check("lw_wait_rdata", rdata, 32'hCAFEF00D);
    check("lw_wait_err", {31'b0, rerr}, 0);
    do_req(EXE_LW, 32'h204, 0, 32'h55555555, 1000);
    check("tmo_err", {31'b0, rerr}, 1);
    check("tmo_rdata", rdata, 0);
    do_req(6'h00, 32'h100, 0, 32'h11111111, 0);
    check("nonmem_lat", lat, 1);
    check("nonmem_en", en_n, 0);
    check("nonmem_err", {31'b0, rerr}, 0);
    check("nonmem_rdata", rdata, 0);
    do_req(EXE_LW, 32'h101, 0, 32'h87654321, 0);
`ifdef LSU_ALIGN_CHECK_EN
    check("mis_en", en_n, 0);
    check("mis_lat", lat, 1);
    check("mis_err", {31'b0, rerr}, 1);
    check("mis_rdata", rdata, 0);
`else
    check("unal_addr", maddr, 32'h100);
    check("unal_lat", lat, 2);
    check("unal_err", {31'b0, rerr}, 0);
    check("unal_rdata", rdata, 32'h87654321);
`endif
    @(negedge clk);
    req_valid = 1; req_op = EXE_LW; req_addr = 32'h300;
    @(posedge clk);
    #1 req_valid = 0;
    @(negedge clk);
    check("abort_busy_en", {31'b0, mem_en}, 1);
    #2 resetn = 0;
    #1 check("abort_en_async", {31'b0, mem_en}, 0);
    seen = resp_valid;
    @(negedge clk);
    resetn = 1;
    check("abort_req_ready", {31'b0, req_ready}, 1);
    repeat (3) begin
      @(negedge clk);
      seen |= resp_valid;
    end
    check("abort_no_resp", {31'b0, seen}, 0);
    do_req(EXE_SH, 32'h202, 32'h00001234, 0, 0);
    check("sh_hi_wen", {28'b0, wen}, 32'hC);
    check("sh_hi_wdata", mwdata, 32'h12341234);
    check("sh_hi_addr", maddr, 32'h200);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
